// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes and x86 arithmetic flags.
// Define ALU_PIPE_MUL_EN to build the unsigned multiplier (op 9); otherwise op 9 reports an error.
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [63:0]        out_flags,
  output logic               out_flags_we,
  output logic               out_wb,
  output logic               out_err
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_OR  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADC = OPW'(2);
  localparam logic [OPW-1:0] OP_SBB = OPW'(3);
  localparam logic [OPW-1:0] OP_AND = OPW'(4);
  localparam logic [OPW-1:0] OP_SUB = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR = OPW'(6);
  localparam logic [OPW-1:0] OP_CMP = OPW'(7);
  localparam logic [OPW-1:0] OP_MOV = OPW'(8);
`ifdef ALU_PIPE_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = OPW'(9);
`endif

  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int OF_BIT = 11;

  // S1 registers
  logic               s1_valid_q, s1_valid_d;
  logic [OPW-1:0]     s1_op_q,    s1_op_d;
  logic [WIDTH-1:0]   s1_a_q,     s1_a_d;
  logic [WIDTH-1:0]   s1_b_q,     s1_b_d;
  logic               s1_cf_q,    s1_cf_d;

  // S2 (output) registers
  logic               out_valid_q,    out_valid_d;
  logic [2*WIDTH-1:0] out_result_q,   out_result_d;
  logic [63:0]        out_flags_q,    out_flags_d;
  logic               out_flags_we_q, out_flags_we_d;
  logic               out_wb_q,       out_wb_d;
  logic               out_err_q,      out_err_d;

  logic s2_adv;
  logic accept;

  // S2 combinational results
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   r;
  logic               cf, of;
  logic               flag_op, mul_op, illegal, wb;
  logic [2*WIDTH-1:0] calc_result;
  logic [63:0]        calc_flags;
  logic [2*WIDTH-1:0] prod;

`ifdef ALU_PIPE_MUL_EN
  assign prod = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
`else
  assign prod = '0;
`endif

  // Handshake: S2 drains when empty or consumer takes it, so S1 can refill the same edge.
  always_comb begin
    s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_adv;
    accept   = in_valid && in_ready;

    s1_valid_d  = accept || (s1_valid_q && !s2_adv);
    s1_op_d     = accept ? in_op : s1_op_q;
    s1_a_d      = accept ? in_a  : s1_a_q;
    s1_b_d      = accept ? in_b  : s1_b_q;
    s1_cf_d     = accept ? in_cf : s1_cf_q;
    out_valid_d = s2_adv || (out_valid_q && !out_ready);
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    sum_w   = '0;
    r       = '0;
    cf      = 1'b0;
    of      = 1'b0;
    flag_op = 1'b1;
    mul_op  = 1'b0;
    illegal = 1'b0;
    wb      = 1'b1;

    case (s1_op_q)
      OP_ADD, OP_ADC: begin
        sum_w = {1'b0, s1_a_q} + {1'b0, s1_b_q}
              + {{WIDTH{1'b0}}, (s1_op_q == OP_ADC) && s1_cf_q};
        r  = sum_w[WIDTH-1:0];
        cf = sum_w[WIDTH];
        of = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (r[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        // The extra top bit of the difference is the borrow.
        sum_w = {1'b0, s1_a_q} - {1'b0, s1_b_q}
              - {{WIDTH{1'b0}}, (s1_op_q == OP_SBB) && s1_cf_q};
        r  = sum_w[WIDTH-1:0];
        cf = sum_w[WIDTH];
        of = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (r[WIDTH-1] != s1_a_q[WIDTH-1]);
        wb = (s1_op_q != OP_CMP);
      end
      OP_OR:  r = s1_a_q | s1_b_q;
      OP_AND: r = s1_a_q & s1_b_q;
      OP_XOR: r = s1_a_q ^ s1_b_q;
      OP_MOV: begin
        r       = s1_b_q;
        flag_op = 1'b0;
      end
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        flag_op = 1'b0;
        mul_op  = 1'b1;
      end
`endif
      default: begin
        flag_op = 1'b0;
        illegal = 1'b1;
        wb      = 1'b0;
      end
    endcase

    calc_flags = '0;
    if (flag_op) begin
      calc_flags[CF_BIT] = cf;
      calc_flags[PF_BIT] = ~^r[7:0];
      calc_flags[ZF_BIT] = (r == '0);
      calc_flags[SF_BIT] = r[WIDTH-1];
      calc_flags[OF_BIT] = of;
    end else if (mul_op) begin
      calc_flags[CF_BIT] = (prod[2*WIDTH-1:WIDTH] != '0);
      calc_flags[OF_BIT] = (prod[2*WIDTH-1:WIDTH] != '0);
    end

    if (illegal)     calc_result = '0;
    else if (mul_op) calc_result = prod;
    else             calc_result = {{WIDTH{1'b0}}, r};
  end

  always_comb begin
    out_result_d   = out_result_q;
    out_flags_d    = out_flags_q;
    out_flags_we_d = out_flags_we_q;
    out_wb_d       = out_wb_q;
    out_err_d      = out_err_q;
    if (s2_adv) begin
      out_result_d   = calc_result;
      out_flags_d    = calc_flags;
      out_flags_we_d = flag_op || mul_op;
      out_wb_d       = wb;
      out_err_d      = illegal;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cf_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cf_q    <= s1_cf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_flags_q    <= '0;
      out_flags_we_q <= 1'b0;
      out_wb_q       <= 1'b0;
      out_err_q      <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_flags_q    <= out_flags_d;
      out_flags_we_q <= out_flags_we_d;
      out_wb_q       <= out_wb_d;
      out_err_q      <= out_err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_flags    = out_flags_q;
  assign out_flags_we = out_flags_we_q;
  assign out_wb       = out_wb_q;
  assign out_err      = out_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=64): directed corner cases plus randomized traffic
// checked against a scoreboard fed by a wide-arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic [W-1:0]   in_a, in_b;
  logic           in_cf;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;
  logic [63:0]    out_flags;
  logic           out_flags_we, out_wb, out_err;

  alu_pipe #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cf(in_cf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_flags_we(out_flags_we), .out_wb(out_wb), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic [63:0]    flags;
    logic           we;
    logic           wb;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic on widened operands, flags read off the true result.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    exp_t e;
    logic [W+1:0] ua, ub, uc, tot;
    logic signed [W+1:0] sa, sb_, sc, st, smax, smin;
    logic [W-1:0] r;
    logic [2*W-1:0] p;
    logic cf, of, arith;
    e = '0;
    ua = {2'b00, a};
    ub = {2'b00, b};
    uc = {{(W+1){1'b0}}, c};
    sa = {{2{a[W-1]}}, a};
    sb_ = {{2{b[W-1]}}, b};
    sc = $signed(uc);
    smax = '0;
    smax[W-2:0] = '1;
    smin = -smax - 1;
    r = '0; cf = 1'b0; of = 1'b0; arith = 1'b1; p = '0;
    if (op != 4'd2 && op != 4'd3) begin
      uc = '0;
      sc = '0;
    end
    case (op)
      4'd0, 4'd2: begin
        tot = ua + ub + uc;
        r   = tot[W-1:0];
        cf  = (tot[W+1:W] != 2'b00);
        st  = sa + sb_ + sc;
        of  = (st > smax) || (st < smin);
      end
      4'd3, 4'd5, 4'd7: begin
        tot = ua - ub - uc;
        r   = tot[W-1:0];
        cf  = (ua < ub + uc);
        st  = sa - sb_ - sc;
        of  = (st > smax) || (st < smin);
      end
      4'd1: r = a | b;
      4'd4: r = a & b;
      4'd6: r = a ^ b;
      4'd8: begin
        arith = 1'b0;
        e.res = {{W{1'b0}}, b};
        e.wb  = 1'b1;
      end
      4'd9: begin
        arith = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res       = p;
        e.flags[0]  = (p > {{W{1'b0}}, {W{1'b1}}});
        e.flags[11] = (p > {{W{1'b0}}, {W{1'b1}}});
        e.we = 1'b1;
        e.wb = 1'b1;
`else
        e.err = 1'b1;
`endif
      end
      default: begin
        arith = 1'b0;
        e.err = 1'b1;
      end
    endcase
    if (arith) begin
      e.res       = {{W{1'b0}}, r};
      e.flags[0]  = cf;
      e.flags[2]  = ($countones(r[7:0]) % 2 == 0);
      e.flags[6]  = (r == '0);
      e.flags[7]  = r[W-1];
      e.flags[11] = of;
      e.we = 1'b1;
      e.wb = (op != 4'd7);
    end
    return e;
  endfunction

  // One clock: drive at negedge, score any output handshake, record any input handshake.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c, input logic ordy, output logic acc);
    exp_t e;
    in_valid = v; in_op = op; in_a = a; in_b = b; in_cf = c; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {127'd0, out_valid}, 128'd0);
      end else begin
        e = sb.pop_front();
        if (e.wb || e.err) check("sb_result", out_result, e.res);
        check("sb_flags", {64'd0, out_flags}, {64'd0, e.flags});
        check("sb_ctrl", {125'd0, out_flags_we, out_wb, out_err}, {125'd0, e.we, e.wb, e.err});
      end
    end
    if (acc) sb.push_back(model(op, a, b, c));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      4:       v = W'(1);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic acc;
    logic [W-1:0] max_v, min_v, a, b;
    logic [2*W-1:0] snap_res;
    logic [63:0] snap_flags;
    logic [3:0] op;
    int sel;
    logic exp_acc [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    max_v = '1;
    min_v = {1'b1, {(W-1){1'b0}}};
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_cf = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_result", out_result, 128'd0);
    check("rst_flags", {64'd0, out_flags}, 128'd0);
    check("rst_ctrl", {125'd0, out_flags_we, out_wb, out_err}, 128'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // ADD max+1 wraps to zero; latency is two edges including the accept edge.
    cycle(1'b1, 4'd0, max_v, W'(1), 1'b0, 1'b1, acc);
    check("lat_not_yet", {127'd0, out_valid}, 128'd0);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    check("add_wrap_valid", {127'd0, out_valid}, 128'd1);
    check("add_wrap_result", out_result, 128'd0);
    check("add_wrap_flags", {64'd0, out_flags}, 128'h45);
    check("add_wrap_wb", {126'd0, out_wb, out_flags_we}, 128'b11);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);

    // SUB min-1 overflows; CMP on the same operands gives the same flags without writeback.
    cycle(1'b1, 4'd5, min_v, W'(1), 1'b0, 1'b1, acc);
    cycle(1'b1, 4'd7, min_v, W'(1), 1'b0, 1'b1, acc);
    check("sub_ovf_result", out_result, {64'd0, 64'h7FFF_FFFF_FFFF_FFFF});
    check("sub_ovf_flags", {64'd0, out_flags}, 128'h804);
    check("sub_ovf_wb", {127'd0, out_wb}, 128'd1);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    check("cmp_flags", {64'd0, out_flags}, 128'h804);
    check("cmp_wb", {126'd0, out_wb, out_flags_we}, 128'b01);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);

    // Illegal op still flows through; the next ADD is unaffected.
    cycle(1'b1, 4'hF, pick(), pick(), 1'b1, 1'b1, acc);
    cycle(1'b1, 4'd0, W'(5), W'(7), 1'b1, 1'b1, acc);
    check("illegal_ctrl", {125'd0, out_err, out_wb, out_flags_we}, 128'b100);
    check("illegal_result", out_result, 128'd0);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    check("after_illegal_err", {127'd0, out_err}, 128'd0);
    check("after_illegal_result", out_result, 128'd12);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);

    // MUL 2^32 * 2^32.
    cycle(1'b1, 4'd9, W'(64'h1_0000_0000), W'(64'h1_0000_0000), 1'b0, 1'b1, acc);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
`ifdef ALU_PIPE_MUL_EN
    check("mul_result", out_result, 128'h1_0000_0000_0000_0000);
    check("mul_flags", {64'd0, out_flags}, 128'h801);
    check("mul_err", {127'd0, out_err}, 128'd0);
`else
    check("mul_disabled_err", {127'd0, out_err}, 128'd1);
    check("mul_disabled_result", out_result, 128'd0);
`endif
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);

    // Back-pressure: two accepts fill the pipe, then in_ready drops and outputs hold.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 8)), pick(), pick(), 1'($urandom), 1'b0, acc);
      check($sformatf("stall_accept_%0d", i), {127'd0, acc}, {127'd0, exp_acc[i]});
      if (i == 2) begin
        snap_res = out_result;
        snap_flags = out_flags;
      end else if (i > 2) begin
        check("stall_hold_valid", {127'd0, out_valid}, 128'd1);
        check("stall_hold_result", out_result, snap_res);
        check("stall_hold_flags", {64'd0, out_flags}, {64'd0, snap_flags});
      end
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    check("stall_drained", 128'(sb.size()), 128'd0);

    // Asynchronous reset with two ops in flight.
    cycle(1'b1, 4'd0, pick(), pick(), 1'b0, 1'b1, acc);
    cycle(1'b1, 4'd6, pick(), pick(), 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'd0, out_valid}, 128'd0);
    check("async_rst_result", out_result, 128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
      check("no_stale_after_rst", {127'd0, out_valid}, 128'd0);
    end

    // Random traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 12);
      op  = (sel <= 9) ? 4'(sel) : 4'($urandom_range(10, 15));
      a   = pick();
      b   = pick();
      cycle($urandom_range(0, 3) != 0, op, a, b, 1'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    check("random_drained", 128'(sb.size()), 128'd0);
    cycle(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, acc);
    check("idle_at_end", {127'd0, out_valid}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
